// File: rtl/sft_pkg.sv
// Shared definitions for the stream arbiter mux: lock FSM encoding.
package sft_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY    = 2'd1;
    localparam logic [ST_W-1:0] ST_RELEASE = 2'd2;

    typedef enum logic [ST_W-1:0] {
        StIdle    = ST_IDLE,
        StBusy    = ST_BUSY,
        StRelease = ST_RELEASE
    } state_e;

endpackage

// File: rtl/axi_tmr_simple_voter.sv
// Bitwise 2-of-3 majority voter for triplicated state registers.
module axi_tmr_simple_voter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] voted_o
);

    // Any single corrupted copy is outvoted by the other two.
    always_comb begin
        voted_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/sft_stream_arb_mux.sv
// Packet-granular stream mux in front of a blocking arbiter. The lock FSM, the selected port and
// the beat counter are triplicated and voted; the output register is a single copy.
module sft_stream_arb_mux
    import sft_pkg::*;
#(
    parameter int unsigned PORTS     = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS-1:0]           s_valid,
    output logic [PORTS-1:0]           s_ready,
    input  logic [PORTS*DATA_W-1:0]    s_data,
    input  logic [PORTS-1:0]           s_last,
    output logic [PORTS-1:0]           arb_request,
    output logic [PORTS-1:0]           arb_acknowledge,
    input  logic [PORTS-1:0]           arb_grant,
    input  logic                       arb_grant_valid,
    input  logic [$clog2(PORTS)-1:0]   arb_grant_encoded,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_last,
    output logic [$clog2(PORTS)-1:0]   m_src,
    output logic                       err_grant,
    output logic                       err_burst
);

    localparam int unsigned SEL_W = $clog2(PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    // Triplicated control state and voted views
    logic [ST_W-1:0]  state_a_q, state_b_q, state_c_q, state_v;
    logic [SEL_W-1:0] sel_a_q, sel_b_q, sel_c_q, sel_v;
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_c_q, cnt_v;
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_d;
    logic [CNT_W-1:0] cnt_d;

    // Single-copy datapath
    logic              m_valid_q, m_last_q, err_grant_q, err_burst_q;
    logic              err_grant_d, err_burst_d;
    logic [DATA_W-1:0] m_data_q;
    logic [SEL_W-1:0]  m_src_q;

    logic              out_accept, in_fire, watchdog, grant_legal, enc_in_range;
    logic [PORTS-1:0]  enc_onehot;

    axi_tmr_simple_voter #(.WIDTH(ST_W)) u_vote_state (
        .a_i     (state_a_q),
        .b_i     (state_b_q),
        .c_i     (state_c_q),
        .voted_o (state_v)
    );

    axi_tmr_simple_voter #(.WIDTH(SEL_W)) u_vote_sel (
        .a_i     (sel_a_q),
        .b_i     (sel_b_q),
        .c_i     (sel_c_q),
        .voted_o (sel_v)
    );

    axi_tmr_simple_voter #(.WIDTH(CNT_W)) u_vote_cnt (
        .a_i     (cnt_a_q),
        .b_i     (cnt_b_q),
        .c_i     (cnt_c_q),
        .voted_o (cnt_v)
    );

    assign state_q     = state_e'(state_v);
    assign arb_request = s_valid;

    // Grant legality, input handshake and watchdog detection
    always_comb begin
        out_accept   = !m_valid_q || m_ready;
        enc_in_range = 32'(arb_grant_encoded) < PORTS;
        enc_onehot   = enc_in_range ? ({{(PORTS-1){1'b0}}, 1'b1} << arb_grant_encoded) : '0;
        grant_legal  = enc_in_range && $onehot(arb_grant) && (arb_grant == enc_onehot) &&
                       |(s_valid & enc_onehot);
        in_fire      = (state_q == StBusy) && s_valid[sel_v] && out_accept;
        watchdog     = (cnt_v == CNT_LAST);
    end

    // Lock FSM next state, per-port ready and arbiter acknowledge
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_v;
        cnt_d           = cnt_v;
        s_ready         = '0;
        arb_acknowledge = '0;
        err_grant_d     = err_grant_q;
        err_burst_d     = err_burst_q;
        case (state_q)
            StIdle: begin
                if (arb_grant_valid) begin
                    if (grant_legal) begin
                        sel_d   = arb_grant_encoded;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        // Acknowledge the bogus grant so the blocking arbiter is not stuck.
                        err_grant_d     = 1'b1;
                        arb_acknowledge = enc_onehot;
                    end
                end
            end
            StBusy: begin
                s_ready[sel_v] = out_accept;
                if (in_fire) begin
                    cnt_d = cnt_v + CNT_W'(1);
                    if (s_last[sel_v] || watchdog) begin
                        state_d = StRelease;
                    end
                    if (watchdog && !s_last[sel_v]) begin
                        err_burst_d = 1'b1;
                    end
                end
            end
            StRelease: begin
                arb_acknowledge[sel_v] = 1'b1;
                state_d                = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // All three copies reload from the voted next state, scrubbing any upset each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_a_q <= ST_IDLE;
            state_b_q <= ST_IDLE;
            state_c_q <= ST_IDLE;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            sel_c_q   <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            cnt_c_q   <= '0;
        end else begin
            state_a_q <= state_d;
            state_b_q <= state_d;
            state_c_q <= state_d;
            sel_a_q   <= sel_d;
            sel_b_q   <= sel_d;
            sel_c_q   <= sel_d;
            cnt_a_q   <= cnt_d;
            cnt_b_q   <= cnt_d;
            cnt_c_q   <= cnt_d;
        end
    end

    // Output register and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_src_q     <= '0;
            err_grant_q <= 1'b0;
            err_burst_q <= 1'b0;
        end else begin
            err_grant_q <= err_grant_d;
            err_burst_q <= err_burst_d;
            if (in_fire) begin
                m_valid_q <= 1'b1;
                m_data_q  <= s_data[32'(sel_v) * DATA_W +: DATA_W];
                m_last_q  <= s_last[sel_v] | watchdog;
                m_src_q   <= sel_v;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign m_src     = m_src_q;
    assign err_grant = err_grant_q;
    assign err_burst = err_burst_q;

endmodule

// File: tb/tb_sft_stream_arb_mux.sv
// Directed bench for sft_stream_arb_mux with a behavioural blocking arbiter and packet sources.
module tb_sft_stream_arb_mux;

    localparam int P  = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int SW = 2;
    localparam int BW = SW + 1 + DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [P-1:0]    s_valid, s_ready, s_last, arb_request, arb_acknowledge, arb_grant;
    logic [P*DW-1:0] s_data;
    logic            arb_grant_valid, m_valid, m_ready, m_last, err_grant, err_burst;
    logic [SW-1:0]   arb_grant_encoded, m_src;
    logic [DW-1:0]   m_data;

    sft_stream_arb_mux #(
        .PORTS     (P),
        .DATA_W    (DW),
        .MAX_BEATS (MB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .s_last            (s_last),
        .arb_request       (arb_request),
        .arb_acknowledge   (arb_acknowledge),
        .arb_grant         (arb_grant),
        .arb_grant_valid   (arb_grant_valid),
        .arb_grant_encoded (arb_grant_encoded),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_last            (m_last),
        .m_src             (m_src),
        .err_grant         (err_grant),
        .err_burst         (err_burst)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, n_extra, out_first_cyc;
    int src_total[P], src_idx[P], first_acc[P], last_acc[P], ack_cnt[P], ack_cyc[P];
    logic [DW-1:0] src_base[P];
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] prev_beat;
    logic          prev_stall, rdy_tog, ovr, arb_locked, model_valid;
    logic [SW-1:0] arb_owner, model_owner, ovr_enc;
    logic [P-1:0]  ovr_grant;

    // Blocking arbiter: grants lowest requester combinationally, holds until acknowledged
    always_comb begin
        model_owner = arb_owner;
        model_valid = arb_locked;
        if (!arb_locked) begin
            for (int p = P - 1; p >= 0; p--) begin
                if (s_valid[p]) begin
                    model_owner = SW'(p);
                    model_valid = 1'b1;
                end
            end
        end
        arb_grant_valid   = ovr ? 1'b1 : model_valid;
        arb_grant_encoded = ovr ? ovr_enc : model_owner;
        arb_grant         = ovr ? ovr_grant :
                            (model_valid ? ({{(P-1){1'b0}}, 1'b1} << model_owner) : '0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int p = 0; p < P; p++) begin
            s_valid[p] = src_idx[p] < src_total[p];
            s_last[p]  = s_valid[p] && (src_idx[p] == src_total[p] - 1);
            s_data[p*DW +: DW] = s_valid[p] ? DW'(src_base[p] + DW'(src_idx[p])) : '0;
        end
    endtask

    // Beats of one packet; a watchdog cut closes every MB-th beat.
    task automatic load_port(input int p, input int n, input logic [DW-1:0] base, input bit push);
        src_total[p] = n;
        src_idx[p]   = 0;
        src_base[p]  = base;
        if (push) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({SW'(p), (i == n - 1) || (i % MB == MB - 1), DW'(base + DW'(i))});
            end
        end
        drive_src();
    endtask

    task automatic clear_stats();
        for (int p = 0; p < P; p++) begin
            first_acc[p] = -1;
            last_acc[p]  = -1;
            ack_cnt[p]   = 0;
            ack_cyc[p]   = -1;
        end
        n_extra       = 0;
        out_first_cyc = -1;
    endtask

    // One clock: sample handshakes at the edge, update stimulus after it, check at the negedge
    task automatic step();
        logic [P-1:0]  hs, ack;
        logic          do_lock, do_unlock;
        logic [SW-1:0] nxt_owner;
        logic [BW-1:0] beat, expv;
        @(posedge clk);
        hs        = s_valid & s_ready;
        ack       = arb_acknowledge;
        do_unlock = arb_locked && arb_acknowledge[arb_owner];
        do_lock   = !arb_locked && model_valid;
        nxt_owner = model_owner;
        for (int p = 0; p < P; p++) begin
            if (hs[p]) begin
                if (first_acc[p] < 0) first_acc[p] = cyc;
                last_acc[p] = cyc;
            end
            if (ack[p]) begin
                ack_cnt[p]++;
                ack_cyc[p] = cyc;
            end
        end
        cyc++;
        #1;
        for (int p = 0; p < P; p++) if (hs[p]) src_idx[p]++;
        if (!rst_n) begin
            arb_locked = 1'b0;
        end else if (!ovr) begin
            if (do_unlock) begin
                arb_locked = 1'b0;
            end else if (do_lock) begin
                arb_locked = 1'b1;
                arb_owner  = nxt_owner;
            end
        end
        m_ready = rdy_tog ? ~m_ready : 1'b1;
        drive_src();
        @(negedge clk);
        beat = {m_src, m_last, m_data};
        if (m_valid && !m_ready) check_eq("s_ready_stall", 64'(s_ready), 64'd0);
        if (prev_stall) check_eq("hold_stable", 64'({m_valid, beat}), 64'({1'b1, prev_beat}));
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_extra++;
            end else begin
                expv = exp_q.pop_front();
                check_eq("beat", 64'(beat), 64'(expv));
                if (out_first_cyc < 0) out_first_cyc = cyc;
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_beat  = beat;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || s_valid != '0 || m_valid) && n < 400) begin
            step();
            n++;
        end
        check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (3) step();
        check_eq({tag, "_extra"}, 64'(n_extra), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check_eq({tag, "_m_data"}, 64'(m_data), 64'd0);
        check_eq({tag, "_m_last"}, 64'(m_last), 64'd0);
        check_eq({tag, "_m_src"}, 64'(m_src), 64'd0);
        check_eq({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check_eq({tag, "_ack"}, 64'(arb_acknowledge), 64'd0);
        check_eq({tag, "_err_grant"}, 64'(err_grant), 64'd0);
        check_eq({tag, "_err_burst"}, 64'(err_burst), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        m_ready = 1'b1;
        rdy_tog = 1'b0;
        ovr = 1'b0;
        ovr_grant = '0;
        ovr_enc = '0;
        arb_locked = 1'b0;
        arb_owner = '0;
        prev_stall = 1'b0;
        prev_beat = '0;
        cyc = 0;
        for (int p = 0; p < P; p++) begin
            src_total[p] = 0;
            src_idx[p]   = 0;
            src_base[p]  = '0;
        end
        drive_src();
        clear_stats();
        repeat (2) @(negedge clk);
        check_reset_vals("rst0");
        rst_n = 1'b1;
        repeat (2) step();

        // Single 4-beat packet from port 0
        clear_stats();
        load_port(0, 4, 16'h0100, 1'b1);
        wait_done("t1");
        check_eq("t1_latency", 64'(out_first_cyc - first_acc[0]), 64'd1);
        check_eq("t1_throughput", 64'(last_acc[0] - first_acc[0]), 64'd3);
        check_eq("t1_ack_cnt", 64'(ack_cnt[0]), 64'd1);
        check_eq("t1_ack_cyc", 64'(ack_cyc[0] - last_acc[0]), 64'd1);

        // Ports 1 and 3 compete; packets must not interleave
        clear_stats();
        load_port(1, 2, 16'h0200, 1'b1);
        load_port(3, 2, 16'h0300, 1'b1);
        wait_done("t2");
        check_eq("t2_gap", 64'(first_acc[3] - last_acc[1]), 64'd3);
        check_eq("t2_ack1", 64'(ack_cnt[1]), 64'd1);
        check_eq("t2_ack3", 64'(ack_cnt[3]), 64'd1);
        check_eq("t2_err_grant", 64'(err_grant), 64'd0);

        // 8-beat packet under a toggling sink; last beat coincides with the watchdog limit
        clear_stats();
        rdy_tog = 1'b1;
        load_port(2, 8, 16'h0400, 1'b1);
        wait_done("t3");
        rdy_tog = 1'b0;
        check_eq("t3_err_burst", 64'(err_burst), 64'd0);
        check_eq("t3_ack2", 64'(ack_cnt[2]), 64'd1);

        // 10-beat packet cut by the watchdog after beat 8
        clear_stats();
        load_port(1, 10, 16'h0500, 1'b1);
        wait_done("t4");
        check_eq("t4_err_burst", 64'(err_burst), 64'd1);
        check_eq("t4_ack1", 64'(ack_cnt[1]), 64'd2);

        // Illegal (non-one-hot) grant
        clear_stats();
        ovr_grant = 4'b0110;
        ovr_enc   = 2'd1;
        ovr       = 1'b1;
        #1;
        check_eq("t5_ack_pulse", 64'(arb_acknowledge), 64'h2);
        check_eq("t5_s_ready", 64'(s_ready), 64'd0);
        step();
        check_eq("t5_err_grant", 64'(err_grant), 64'd1);
        check_eq("t5_m_valid", 64'(m_valid), 64'd0);
        ovr = 1'b0;
        step();
        check_eq("t5_s_ready_after", 64'(s_ready), 64'd0);
        load_port(0, 1, 16'h0800, 1'b1);
        wait_done("t5");
        check_eq("t5_ack0", 64'(ack_cnt[0]), 64'd1);

        // Reset in the middle of a packet
        clear_stats();
        load_port(0, 4, 16'h0600, 1'b0);
        exp_q.push_back({2'd0, 1'b0, 16'h0600});
        exp_q.push_back({2'd0, 1'b0, 16'h0601});
        n = 0;
        while (src_idx[0] < 2 && n < 50) begin
            step();
            n++;
        end
        check_eq("t6_two_beats", 64'(src_idx[0]), 64'd2);
        rst_n = 1'b0;
        src_total[0] = 0;
        arb_locked = 1'b0;
        drive_src();
        #1;
        check_reset_vals("rst1");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Clean packet while one FSM copy is upset
        clear_stats();
        load_port(2, 3, 16'h0700, 1'b1);
        step();
        force dut.state_b_q = 2'd0;
        step();
        step();
        release dut.state_b_q;
        wait_done("t6");
        check_eq("t6_ack2", 64'(ack_cnt[2]), 64'd1);
        check_eq("t6_err_grant", 64'(err_grant), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
